// File: rtl/game_tick_gen_if.sv
// Game-timing bundle between the divider/collision logic and game_tick_gen.
// The slave side is the tick generator; the master side drives divider and controls.
interface game_tick_gen_if;
    logic [31:0] clkdiv;
    logic        start;
    logic        hit;
    logic [1:0]  state;
    logic        frame_tick;
    logic        scroll_tick;
    logic [2:0]  speed_level;
    logic [15:0] frame_count;
    logic        anim_phase;

    modport master (
        output clkdiv, start, hit,
        input  state, frame_tick, scroll_tick,
        input  speed_level, frame_count, anim_phase
    );

    modport slave (
        input  clkdiv, start, hit,
        output state, frame_tick, scroll_tick,
        output speed_level, frame_count, anim_phase
    );
endinterface

// File: rtl/game_tick_gen.sv
// Turns one divider bit into frame/scroll clock enables and tracks
// the run/over state, frame score and speed level.
module game_tick_gen #(
    parameter int FRAME_TAP    = 20,
    parameter int LEVEL_FRAMES = 512,
    parameter int ANIM_BIT     = 3
) (
    input  logic           clk,
    input  logic           rst,
    game_tick_gen_if.slave bus
);
    localparam int LW = (LEVEL_FRAMES > 2) ? $clog2(LEVEL_FRAMES) : 1;
    localparam logic [LW-1:0] LVL_MAX = LW'(LEVEL_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            tap_q;
    logic            tap_edge;
    logic            enter_run;
    logic            scroll_hit;
    logic            frame_tick_q;
    logic            scroll_tick_q;
    logic [2:0]      level_q;
    logic [2:0]      scnt_q;
    logic [15:0]     fcnt_q;
    logic [LW-1:0]   lvl_cnt_q;
    logic            unused_div;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.hit)   state_d = OVER;
            OVER:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign tap_edge   = bus.clkdiv[FRAME_TAP] & ~tap_q & (state_q == RUN);
    assign enter_run  = (state_q != RUN) & (state_d == RUN);
    assign scroll_hit = (scnt_q == (3'd7 - level_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tap_q         <= 1'b0;
            frame_tick_q  <= 1'b0;
            scroll_tick_q <= 1'b0;
            level_q       <= 3'd0;
            scnt_q        <= 3'd0;
            fcnt_q        <= 16'd0;
            lvl_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            tap_q         <= bus.clkdiv[FRAME_TAP];
            frame_tick_q  <= tap_edge;
            scroll_tick_q <= tap_edge & scroll_hit;
            // Edge needs RUN and entry needs non-RUN, so they never coincide
            if (enter_run) begin
                level_q   <= 3'd0;
                scnt_q    <= 3'd0;
                fcnt_q    <= 16'd0;
                lvl_cnt_q <= '0;
            end else if (tap_edge) begin
                scnt_q <= scroll_hit ? 3'd0 : scnt_q + 3'd1;
                if (fcnt_q != 16'hFFFF)
                    fcnt_q <= fcnt_q + 16'd1;
                if (lvl_cnt_q == LVL_MAX) begin
                    lvl_cnt_q <= '0;
                    if (level_q != 3'd7)
                        level_q <= level_q + 3'd1;
                end else begin
                    lvl_cnt_q <= lvl_cnt_q + LW'(1);
                end
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.scroll_tick = scroll_tick_q;
    assign bus.speed_level = level_q;
    assign bus.frame_count = fcnt_q;
    assign bus.anim_phase  = fcnt_q[ANIM_BIT];

    assign unused_div = &{1'b0, bus.clkdiv};
endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen: two instances (LEVEL_FRAMES 64 and 4)
// share the divider and controls; FRAME_TAP=2 gives a frame every 8 cycles.
module tb_game_tick_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] div;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    typedef struct {
        int          frame;
        logic [15:0] cnt;
        logic        scr_a;
        logic        anim_a;
        logic [2:0]  lvl_b;
        logic        scr_b;
    } vec_t;

    vec_t tbl[40];

    game_tick_gen_if ifa ();
    game_tick_gen_if ifb ();

    assign ifa.clkdiv = div;
    assign ifa.start  = start;
    assign ifa.hit    = hit;
    assign ifb.clkdiv = div;
    assign ifb.start  = start;
    assign ifb.hit    = hit;

    game_tick_gen #(.FRAME_TAP(2), .LEVEL_FRAMES(64), .ANIM_BIT(3)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    game_tick_gen #(.FRAME_TAP(2), .LEVEL_FRAMES(4), .ANIM_BIT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div <= 32'd0;
        else     div <= div + 32'd1;
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Count ticks from either instance over n cycles
    task automatic quiet(input int n, input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ifa.frame_tick || ifb.frame_tick ||
                ifa.scroll_tick || ifb.scroll_tick) seen++;
        end
        chk(nm, seen, 0);
    endtask

    task automatic wait_tick(output int k);
        k = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (ifa.frame_tick) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_pre_edge(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (div[2:0] == 3'd4) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        int last;
        bit ok;

        for (int f = 1; f <= 40; f++) begin
            tbl[f-1].frame  = f;
            tbl[f-1].cnt    = 16'(f);
            tbl[f-1].scr_a  = (f % 8 == 0);
            tbl[f-1].anim_a = ((f / 8) % 2) == 1;
            tbl[f-1].lvl_b  = (f / 4 > 7) ? 3'd7 : 3'(f / 4);
            tbl[f-1].scr_b  = (f == 7) || (f == 19) || (f == 22) || (f >= 31);
        end

        // 1: reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet(100, "idle_ticks");
        chk("idle_state", ifa.state, 0);
        chk("idle_cnt", ifa.frame_count, 0);
        chk("idle_lvl", ifa.speed_level, 0);
        chk("idle_anim", ifa.anim_phase, 0);

        // 2 and 3: 40 frames on both instances
        pulse_start();
        chk("run_state", ifa.state, 1);
        last = 0;
        for (int i = 0; i < 40; i++) begin
            wait_tick(k);
            if (k == 0) begin
                chk($sformatf("f%0d_timeout", tbl[i].frame), 0, 1);
                break;
            end
            if (i > 0)
                chk($sformatf("f%0d_period", tbl[i].frame), cyc - last, 8);
            last = cyc;
            chk($sformatf("f%0d_cnt_a", tbl[i].frame), ifa.frame_count, tbl[i].cnt);
            chk($sformatf("f%0d_scr_a", tbl[i].frame), ifa.scroll_tick, tbl[i].scr_a);
            chk($sformatf("f%0d_anim_a", tbl[i].frame), ifa.anim_phase, tbl[i].anim_a);
            chk($sformatf("f%0d_lvl_a", tbl[i].frame), ifa.speed_level, 0);
            chk($sformatf("f%0d_tick_b", tbl[i].frame), ifb.frame_tick, 1);
            chk($sformatf("f%0d_cnt_b", tbl[i].frame), ifb.frame_count, tbl[i].cnt);
            chk($sformatf("f%0d_lvl_b", tbl[i].frame), ifb.speed_level, tbl[i].lvl_b);
            chk($sformatf("f%0d_scr_b", tbl[i].frame), ifb.scroll_tick, tbl[i].scr_b);
            @(negedge clk);
            chk($sformatf("f%0d_width", tbl[i].frame), ifa.frame_tick, 0);
            chk($sformatf("f%0d_scrw", tbl[i].frame), ifa.scroll_tick | ifb.scroll_tick, 0);
        end

        // 4: hit off-edge, hold in OVER, restart on a tap edge
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        chk("over_state", ifa.state, 2);
        quiet(20, "over_ticks");
        chk("over_cnt_a", ifa.frame_count, 40);
        chk("over_lvl_b", ifb.speed_level, 7);
        wait_pre_edge(ok);
        chk("pre_edge_found", ok, 1);
        pulse_start();
        chk("restart_state", ifa.state, 1);
        chk("restart_tick", ifa.frame_tick, 0);
        chk("restart_cnt_a", ifa.frame_count, 0);
        chk("restart_cnt_b", ifb.frame_count, 0);
        chk("restart_lvl_b", ifb.speed_level, 0);
        wait_tick(k);
        chk("restart_first_tick", k, 8);
        for (int i = 2; i <= 9; i++) begin
            wait_tick(k);
            if (k == 0) begin
                chk("hitrun_timeout", 0, 1);
                break;
            end
        end
        chk("pre_hit_cnt", ifa.frame_count, 9);
        wait_pre_edge(ok);
        chk("hit_edge_found", ok, 1);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        chk("hit_tick", ifa.frame_tick, 1);
        chk("hit_cnt", ifa.frame_count, 10);
        chk("hit_state", ifa.state, 2);
        quiet(40, "post_hit_ticks");
        chk("post_hit_cnt", ifa.frame_count, 10);

        // 5: start and hit together in RUN, then hit alone in OVER
        pulse_start();
        chk("s5_run", ifa.state, 1);
        chk("s5_clear", ifa.frame_count, 0);
        start = 1'b1;
        hit   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s5_both", ifa.state, 2);
        @(negedge clk);
        hit = 1'b0;
        chk("s5_hit_over", ifa.state, 2);

        // 6: asynchronous reset mid-frame at frame_count 5
        pulse_start();
        for (int i = 1; i <= 5; i++) begin
            wait_tick(k);
            if (k == 0) begin
                chk("s6_timeout", 0, 1);
                break;
            end
        end
        chk("s6_cnt5", ifa.frame_count, 5);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_state", ifa.state, 0);
        chk("rst_cnt", ifa.frame_count, 0);
        chk("rst_lvl", ifb.speed_level, 0);
        chk("rst_ticks", {ifa.frame_tick, ifa.scroll_tick}, 0);
        chk("rst_anim", ifa.anim_phase, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet(100, "post_rst_ticks");
        chk("post_rst_state", ifa.state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Frame-timing stage that sits directly downstream of the free-running 32-bit clock-divider counter. It turns one selected counter bit into single-cycle game-clock enables: a frame tick, and a scroll tick whose period shrinks as the game speeds up. It also keeps the run/over game state, the frame-based score and the speed level. Renderer, obstacle and dino logic consume its outputs as clock enables on `clk`; they never use divider bits as clocks.

## Interface
Parameters:
- `FRAME_TAP`, default 20: index of the `clkdiv` bit whose rising edge defines a frame.
- `LEVEL_FRAMES`, default 512: frames per speed-level step. Must be ≥2.
- `ANIM_BIT`, default 3: bit of `frame_count` driven out as `anim_phase`.

Ports:
- `clk` in 1: system clock, the same clock that drives the divider.
- `rst` in 1: reset, asynchronous, active-high.
- `clkdiv` in 32: divider count, registered in the `clk` domain.
- `start` in 1: one-cycle request to start or restart a game.
- `hit` in 1: collision flag from the obstacle logic, sampled each cycle.
- `state` out 2: game state; 0=IDLE, 1=RUN, 2=OVER.
- `frame_tick` out 1: one-cycle frame enable; high only in RUN.
- `scroll_tick` out 1: one-cycle scroll enable; only ever high together with `frame_tick`.
- `speed_level` out 3: current speed level, 0..7.
- `frame_count` out 16: score in frames, saturating.
- `anim_phase` out 1: `frame_count[ANIM_BIT]`.

## Operation
- Edge detect:
  - `tap_q <= clkdiv[FRAME_TAP]` every cycle.
  - `edge = clkdiv[FRAME_TAP] & ~tap_q & (state==RUN)`.
- FSM, evaluated every cycle:
  - IDLE: `start` goes to RUN.
  - RUN: `hit` goes to OVER. `start` is ignored.
  - OVER: `start` goes to RUN. `hit` is ignored.
  - State encoding 3 is unreachable and recovers to IDLE on the next cycle.
- Entering RUN, from IDLE or OVER, clears `frame_count`, `speed_level`, `lvl_cnt` and `scnt` in the same cycle.
- On a cycle with `edge` high, all updates use the pre-update register values:
  - `frame_tick <= 1`.
  - `scroll_tick <= (scnt == 7 - speed_level)`. If true, `scnt <= 0`; else `scnt <= scnt+1`. `scnt` is 3 bits.
  - `frame_count <= frame_count+1`, saturating at 0xFFFF. It never wraps.
  - `lvl_cnt` counts 0..`LEVEL_FRAMES-1`. On reaching `LEVEL_FRAMES-1` it wraps to 0 and `speed_level` increments, saturating at 7.
- The scroll period is therefore `8 - speed_level` frames: 8 frames at level 0, 1 frame (every frame) at level 7.
- In OVER, all counters hold their values, so the score and level stay visible. No ticks are produced.
- `hit` and `edge` in the same cycle: the tick and counter update still happen, and the state moves to OVER. That frame is counted.

## Timing
- Reset values:
  - `state`=IDLE.
  - `frame_tick`=0, `scroll_tick`=0.
  - `speed_level`=0, `frame_count`=0, `anim_phase`=0.
  - `tap_q`=0, `lvl_cnt`=0, `scnt`=0.
- Reset is asynchronous, takes effect mid-game, and no tick is emitted while `rst` is high.
- Latency: `frame_tick` goes high one cycle after the first cycle in which `clkdiv[FRAME_TAP]` reads 1.
  - `frame_tick` is exactly one cycle wide.
  - Ticks repeat every 2^(FRAME_TAP+1) cycles.
- `frame_count`, `speed_level` and `scnt` update on the same edge that raises `frame_tick`. Their new values are visible in the cycle `frame_tick` is high.
- A `start` in the same cycle as a tap edge while in IDLE or OVER produces no tick for that edge, because state is not yet RUN. The first tick comes on the next tap edge.
- A `start` and `hit` together in RUN: `hit` wins and the state goes to OVER.
- `state` changes one cycle after `start` or `hit` is sampled.
- All outputs are registered, except `anim_phase`, which is a direct wire from a register bit.

## Test plan
Bench parameters: `FRAME_TAP=2`, so a frame is every 8 cycles. The divider model is reset by the same `rst`.
1. Reset, no `start` for 100 cycles -> `state`=0, `frame_tick` never high, all counters 0.
2. `start` pulse, `LEVEL_FRAMES=64` -> `frame_tick` every 8 cycles, each one cycle wide; `scroll_tick` on frames 8, 16 and 24 only; `frame_count`=24 after 24 ticks; `anim_phase` toggles every 8 frames.
3. `LEVEL_FRAMES=4`, run 40 frames -> `speed_level` reads 1 after frame 4 and 7 after frame 28, and stays 7 through frame 40; at level 7, `scroll_tick` accompanies every `frame_tick`.
4. `hit` coincident with a tick at frame 10 -> `frame_count`=10, `state`=2 next cycle, no further ticks; `start` -> `state`=1, counters 0, first tick on the next tap edge.
5. `start` and `hit` asserted together in RUN -> `state`=2; in OVER, `hit` alone leaves the state at 2.
6. Assert `rst` mid-frame during RUN at `frame_count`=5 -> all outputs 0 and `state`=0 immediately (asynchronous); no tick for 100 cycles after release without `start`.
